// File: rtl/inst_sequencer.sv
// inst_sequencer: stores a short program of {io_inst, inst} pairs loaded by
// the host and replays it one entry per cycle, padding every matmul-class
// entry with NOP cycles so the accelerator's matmul latency is covered.
module inst_sequencer #(
  parameter int DEPTH  = 16,
  parameter int MM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_valid,
  output logic        prog_ready,
  input  logic [63:0] prog_data,
  input  logic        prog_clear,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] inst,
  output logic [31:0] io_inst
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = IW + 1;
  localparam int WW = (MM_LAT > 2) ? $clog2(MM_LAT) : 1;
  // Reload value of the wait counter: the matmul cycle itself plus WLOAD+1
  // WAIT cycles gives MM_LAT cycles in total.
  localparam logic [WW-1:0] WLOAD = (MM_LAT > 2) ? WW'(MM_LAT - 2) : {WW{1'b0}};
  localparam logic PAD = (MM_LAT > 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     io_inst_q, io_inst_d;
  logic [63:0]     mem [DEPTH];

  logic            idle_s;
  logic            wr_en_s;
  logic            last_s;
  logic            mm_s;
  logic [63:0]     next_entry_s;

  assign idle_s       = (state_q == S_IDLE);
  assign prog_ready   = idle_s && (cnt_q < CW'(DEPTH));
  assign wr_en_s      = prog_valid && prog_ready && !prog_clear;
  assign busy         = !idle_s;
  assign done         = (state_q == S_DONE);
  assign inst         = inst_q;
  assign io_inst      = io_inst_q;
  // The entry currently presented is held in inst_q, so its class is read there.
  assign mm_s         = (inst_q[31:30] != 2'b00);
  assign last_s       = (({1'b0, idx_q} + CW'(1)) == cnt_q);
  assign next_entry_s = mem[idx_q + IW'(1)];

  // Program storage: written only on an accepted host handshake; never reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[cnt_q[IW-1:0]] <= prog_data;
    end else begin
      mem[cnt_q[IW-1:0]] <= mem[cnt_q[IW-1:0]];
    end
  end

  // Next-state and next-output computation for the load/replay sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    inst_d    = 32'd0;
    io_inst_d = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (prog_clear) begin
          cnt_d = {CW{1'b0}};
        end else begin
          if (wr_en_s) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q;
          end
          if (!start) begin
            state_d = S_IDLE;
          end else if (cnt_d == {CW{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            idx_d   = {IW{1'b0}};
            // An entry written in this very cycle into an empty program is
            // not yet in the array, so it is forwarded straight from the port.
            if (cnt_q == {CW{1'b0}}) begin
              {io_inst_d, inst_d} = prog_data;
            end else begin
              {io_inst_d, inst_d} = mem[0];
            end
          end
        end
      end
      S_ISSUE, S_WAIT: begin
        if ((state_q == S_ISSUE) && mm_s && PAD) begin
          wcnt_d  = WLOAD;
          state_d = S_WAIT;
        end else if ((state_q == S_WAIT) && (wcnt_q != {WW{1'b0}})) begin
          wcnt_d = wcnt_q - WW'(1);
        end else if (last_s) begin
          state_d = S_DONE;
        end else begin
          idx_d               = idx_q + IW'(1);
          {io_inst_d, inst_d} = next_entry_s;
          state_d             = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      idx_q     <= {IW{1'b0}};
      wcnt_q    <= {WW{1'b0}};
      inst_q    <= 32'd0;
      io_inst_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      inst_q    <= inst_d;
      io_inst_q <= io_inst_d;
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Testbench for inst_sequencer: a queue-based program model predicts the
// exact per-cycle output stream (entries, NOP padding, done, idle).
module tb_inst_sequencer;

  localparam int DEPTH  = 16;
  localparam int MM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prog_valid = 1'b0;
  logic        prog_ready;
  logic [63:0] prog_data = 64'd0;
  logic        prog_clear = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] inst;
  logic [31:0] io_inst;

  int checks = 0;
  int errors = 0;

  // Model: the stored program, and expected/observed per-cycle samples
  // laid out as {prog_ready, busy, done, io_inst, inst}.
  logic [63:0] prog_m [$];
  logic [66:0] exp_q [$];
  logic [66:0] obs_q [$];

  always #5 clk = ~clk;

  inst_sequencer #(.DEPTH(DEPTH), .MM_LAT(MM_LAT)) dut (
    .clk(clk), .rst(rst), .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_data(prog_data), .prog_clear(prog_clear), .start(start),
    .busy(busy), .done(done), .inst(inst), .io_inst(io_inst)
  );

  function automatic logic [63:0] rand_entry();
    logic [63:0] e;
    e = {$urandom, $urandom};
    if ($urandom_range(1, 0) == 0) e[31:30] = 2'b00;
    return e;
  endfunction

  // Expected stream for `runs` replays, each followed by DONE and one idle cycle.
  function automatic void build_exp(input int runs);
    exp_q = {};
    for (int r = 0; r < runs; r++) begin
      foreach (prog_m[i]) begin
        exp_q.push_back({3'b010, prog_m[i]});
        if (prog_m[i][31:30] != 2'b00)
          for (int j = 0; j < MM_LAT - 1; j++) exp_q.push_back({3'b010, 64'd0});
      end
      exp_q.push_back({3'b011, 64'd0});
      exp_q.push_back({(prog_m.size() < DEPTH), 2'b00, 64'd0});
    end
  endfunction

  task automatic load(input logic [63:0] e);
    prog_valid = 1'b1;
    prog_data  = e;
    @(negedge clk);
    prog_valid = 1'b0;
    if (prog_m.size() < DEPTH) prog_m.push_back(e);
  endtask

  task automatic clear_prog();
    prog_clear = 1'b1;
    @(negedge clk);
    prog_clear = 1'b0;
    prog_m = {};
  endtask

  // Holds start high and records one sample per cycle until `runs` idle
  // cycles have been seen (bounded). Optionally offers writes while busy.
  task automatic capture(input int runs, input bit poke, input bit first_valid,
                         input logic [63:0] first_data);
    int idles = 0;
    int cyc = 0;
    obs_q = {};
    start = 1'b1;
    prog_valid = first_valid;
    prog_data = first_data;
    if (first_valid && prog_m.size() < DEPTH) prog_m.push_back(first_data);
    @(negedge clk);
    while (idles < runs && cyc < 1000) begin
      obs_q.push_back({prog_ready, busy, done, io_inst, inst});
      if (!busy) idles++;
      prog_valid = poke && busy;
      prog_data = {$urandom, $urandom};
      cyc++;
      if (idles < runs) @(negedge clk);
    end
    start = 1'b0;
    prog_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({inst, io_inst, busy, done, prog_ready} !== {64'd0, 3'b001}) begin
      errors++;
      $display("FAIL reset_state got %h want %h", {inst, io_inst, busy, done, prog_ready}, {64'd0, 3'b001});
    end
    load({32'h0000_0011, 32'h0C00_0000});
    load({32'h0000_0022, 32'h0300_0000});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, io_inst, inst} !== {1'b1, 32'h0000_0011, 32'h0C00_0000}) begin
      errors++;
      $display("FAIL reset_prereplay got %h want %h", {busy, io_inst, inst}, {1'b1, 32'h0000_0011, 32'h0C00_0000});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({inst, io_inst, busy, done} !== {64'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_midreplay got %h want %h", {inst, io_inst, busy, done}, {64'd0, 2'b00});
    end
    @(negedge clk);
    rst = 1'b1;
    prog_m = {};
    @(negedge clk);
    capture(1, 1'b0, 1'b0, 64'd0);
    build_exp(1);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL reset_empty_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_empty[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_three();
    clear_prog();
    load({32'h0000_0011, 32'h0C00_0000});
    load({32'h0000_0022, 32'h0300_0000});
    load({32'h0000_0033, 32'h00C0_0000});
    capture(1, 1'b0, 1'b0, 64'd0);
    build_exp(1);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL three_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL three[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_matmul();
    int issue_cycles = 0;
    clear_prog();
    load({32'h0000_000A, 32'h0000_0001});
    load({32'h0000_0055, 32'h4000_0000});
    load({32'h0000_000B, 32'h0000_0002});
    capture(1, 1'b0, 1'b0, 64'd0);
    build_exp(1);
    foreach (obs_q[i]) if (obs_q[i][65:64] == 2'b10) issue_cycles++;
    checks++;
    if (issue_cycles != 6) begin
      errors++;
      $display("FAIL matmul_issue_cycles got %0d want 6", issue_cycles);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL matmul_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL matmul[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fill();
    int hs = 0;
    clear_prog();
    for (int c = 0; c < 20; c++) begin
      prog_valid = 1'b1;
      prog_data = rand_entry();
      checks++;
      if (prog_ready !== (prog_m.size() < DEPTH)) begin
        errors++;
        $display("FAIL fill_ready[%0d] got %b want %b", c, prog_ready, (prog_m.size() < DEPTH));
      end
      if (prog_ready) hs++;
      if (prog_m.size() < DEPTH) prog_m.push_back(prog_data);
      @(negedge clk);
    end
    prog_valid = 1'b0;
    checks++;
    if (hs != DEPTH || prog_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_handshakes got %0d/%b want %0d/0", hs, prog_ready, DEPTH);
    end
    capture(1, 1'b0, 1'b0, 64'd0);
    build_exp(1);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL fill_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL fill[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_same_cycle();
    clear_prog();
    capture(1, 1'b0, 1'b1, {32'hCAFE_0001, 32'h1234_5678});
    build_exp(1);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL bypass_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bypass[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    load(rand_entry());
    prog_clear = 1'b1;
    start = 1'b1;
    prog_valid = 1'b1;
    prog_data = rand_entry();
    @(negedge clk);
    prog_clear = 1'b0;
    start = 1'b0;
    prog_valid = 1'b0;
    prog_m = {};
    @(negedge clk);
    checks++;
    if ({busy, done, prog_ready} !== 3'b001) begin
      errors++;
      $display("FAIL clear_start got %b want 001", {busy, done, prog_ready});
    end
    capture(1, 1'b0, 1'b0, 64'd0);
    build_exp(1);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL clear_empty_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL clear_empty[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 3; it++) begin
      clear_prog();
      for (int n = $urandom_range(DEPTH, 1); n > 0; n--) load(rand_entry());
      // Start held high across two replays, with writes offered while busy.
      capture(2, 1'b1, 1'b0, 64'd0);
      build_exp(2);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL b2b_len[%0d] got %0d want %0d", it, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b[%0d][%0d] got %h want %h", it, i, obs_q[i], exp_q[i]);
        end
      end
      @(negedge clk);
      capture(1, 1'b0, 1'b0, 64'd0);
      build_exp(1);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL replay_again_len[%0d] got %0d want %0d", it, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL replay_again[%0d][%0d] got %h want %h", it, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_three();
    test_matmul();
    test_fill();
    test_same_cycle();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
